// File: rtl/upg_pkg.sv
// Shared types and constants for the UART programming loader.
// UPG_CHECKSUM_EN adds the trailing checksum state.
package upg_pkg;

    localparam logic [7:0] CMD_IMEM = 8'h00;
    localparam logic [7:0] CMD_DMEM = 8'h01;
    localparam int unsigned TIMEOUT_DEFAULT = 1_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA
`ifdef UPG_CHECKSUM_EN
        , ST_CHK
`endif
    } state_t;

endpackage

// File: rtl/upg_word_packer.sv
// Little-endian byte-to-word assembler; 'full' flags the byte that completes a word.
module upg_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        full
);

    logic [31:0] shreg;
    logic [1:0]  cnt;

    // word is the value after shifting in the current byte, so a write can be registered on this edge
    always_comb begin
        word = {in_byte, shreg[31:8]};
        full = in_valid && (cnt == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (in_valid) begin
            shreg <= word;
            cnt   <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/upg_loader.sv
// UART frame parser driving the memory programming port (CMD, LEN_L, LEN_H, data[, CHK]).
// Define UPG_CHECKSUM_EN to require the trailing XOR checksum byte.
module upg_loader
    import upg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int unsigned ADDR_W         = 14
) (
    input  logic              upg_clk_i,
    input  logic              upg_rst_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_sel_o,
    output logic              upg_done_o,
    output logic              err_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef UPG_CHECKSUM_EN
    localparam state_t END_ST = ST_CHK;
`else
    localparam state_t END_ST = ST_IDLE;
`endif

    state_t            state, next_state;
    logic [7:0]        len_l;
    logic [15:0]       len;
    logic [15:0]       len_new;
    logic [ADDR_W-1:0] widx;
    logic [TW-1:0]     idle_cnt;
    logic              fire, live, is_cmd, too_big, last_word;
    logic              accept_cmd, bad_cmd, len_err, pack_en, pack_clr, word_wr, chk_bad;
    logic [31:0]       word_next;
    logic              word_full;
`ifdef UPG_CHECKSUM_EN
    logic [7:0]        chk_acc;
`endif

    upg_word_packer u_packer (
        .clk      (upg_clk_i),
        .rst      (upg_rst_i),
        .clear    (pack_clr),
        .in_valid (pack_en),
        .in_byte  (rx_data_i),
        .word     (word_next),
        .full     (word_full)
    );

    always_ff @(posedge upg_clk_i) begin
        if (upg_rst_i) state <= ST_IDLE;
        else           state <= next_state;
    end

    always_comb begin
        fire      = (state != ST_IDLE) && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
        is_cmd    = (rx_data_i == CMD_IMEM) || (rx_data_i == CMD_DMEM);
        len_new   = {rx_data_i, len_l};
        too_big   = {16'd0, len_new} > (32'd1 << ADDR_W);
        last_word = ({16'd0, len} - 32'd1) == 32'(widx);
    end

    always_comb begin
        next_state = state;
        if (fire) begin
            next_state = ST_IDLE;
        end else if (rx_valid_i) begin
            case (state)
                ST_IDLE: if (is_cmd) next_state = ST_LEN0;
                ST_LEN0: next_state = ST_LEN1;
                ST_LEN1: begin
                    if (len_new == 16'd0) next_state = END_ST;
                    else if (too_big)     next_state = ST_IDLE;
                    else                  next_state = ST_DATA;
                end
                ST_DATA: if (word_full && last_word) next_state = END_ST;
`ifdef UPG_CHECKSUM_EN
                ST_CHK:  next_state = ST_IDLE;
`endif
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // a byte coinciding with the timeout is dropped entirely
    always_comb begin
        live       = rx_valid_i && !fire;
        accept_cmd = live && (state == ST_IDLE) && is_cmd;
        bad_cmd    = live && (state == ST_IDLE) && !is_cmd;
        len_err    = live && (state == ST_LEN1) && (len_new != 16'd0) && too_big;
        pack_en    = live && (state == ST_DATA);
        pack_clr   = fire || accept_cmd;
        word_wr    = word_full;
`ifdef UPG_CHECKSUM_EN
        chk_bad    = live && (state == ST_CHK) && (rx_data_i != chk_acc);
`else
        chk_bad    = 1'b0;
`endif
    end

    always_ff @(posedge upg_clk_i) begin
        if (upg_rst_i) begin
            upg_wen_o  <= 1'b0;
            upg_adr_o  <= '0;
            upg_dat_o  <= '0;
            upg_sel_o  <= 1'b0;
            upg_done_o <= 1'b1;
            err_o      <= 1'b0;
            len_l      <= '0;
            len        <= '0;
            widx       <= '0;
            idle_cnt   <= '0;
        end else begin
            upg_wen_o <= word_wr;
            if (word_wr) begin
                upg_adr_o <= widx;
                upg_dat_o <= word_next;
                widx      <= widx + 1'b1;
            end
            if (accept_cmd) begin
                upg_sel_o <= rx_data_i[0];
                widx      <= '0;
                err_o     <= 1'b0;
            end
            if (bad_cmd || len_err || fire || chk_bad) err_o <= 1'b1;
            if (live && (state == ST_LEN0)) len_l <= rx_data_i;
            if (live && (state == ST_LEN1)) len <= len_new;
            // done trails the final write pulse by one cycle
            upg_done_o <= (next_state == ST_IDLE) && !word_wr;
            if (rx_valid_i || fire || (state == ST_IDLE)) idle_cnt <= '0;
            else                                          idle_cnt <= idle_cnt + 1'b1;
        end
    end

`ifdef UPG_CHECKSUM_EN
    always_ff @(posedge upg_clk_i) begin
        if (upg_rst_i || accept_cmd) chk_acc <= '0;
        else if (live && (state == ST_LEN0 || state == ST_LEN1 || state == ST_DATA))
            chk_acc <= chk_acc ^ rx_data_i;
    end
`endif

endmodule

// File: tb/tb_upg_loader.sv
// Directed bench for upg_loader: vector table for the main frames, hand sequences for timeout/reset/checksum.
module tb_upg_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        wen;
    logic [13:0] adr;
    logic [31:0] dat;
    logic        sel;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        wen;
        logic [13:0] adr;
        logic [31:0] dat;
        logic        sel;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    upg_loader #(.TIMEOUT_CYCLES(16), .ADDR_W(14)) dut (
        .upg_clk_i  (clk),
        .upg_rst_i  (rst),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .upg_wen_o  (wen),
        .upg_adr_o  (adr),
        .upg_dat_o  (dat),
        .upg_sel_o  (sel),
        .upg_done_o (done),
        .err_o      (err)
    );

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic w,
                                input logic [13:0] a, input logic [31:0] dt,
                                input logic s, input logic dn, input logic e);
        vec_t r;
        r.v = v; r.d = d; r.wen = w; r.adr = a; r.dat = dt; r.sel = s; r.done = dn; r.err = e;
        return r;
    endfunction

    function automatic logic [63:0] ex(input logic w, input logic [13:0] a, input logic [31:0] dt,
                                       input logic s, input logic dn, input logic e);
        return {14'd0, w, a, dt, s, dn, e};
    endfunction

    function automatic logic [63:0] obs();
        return {14'd0, wen, adr, dat, sel, done, err};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        logic saw_wen;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        tick(); tick();
        check("reset_vals", obs(), ex(0, 14'd0, 32'h0, 0, 1, 0));
        rst = 1'b0;

`ifndef UPG_CHECKSUM_EN
        // frame 1: imem, N=2
        vq.push_back(mk(1, 8'h00, 0, 14'd0, 32'h0, 0, 0, 0));
        vq.push_back(mk(1, 8'h02, 0, 14'd0, 32'h0, 0, 0, 0));
        vq.push_back(mk(1, 8'h00, 0, 14'd0, 32'h0, 0, 0, 0));
        vq.push_back(mk(1, 8'h78, 0, 14'd0, 32'h0, 0, 0, 0));
        vq.push_back(mk(1, 8'h56, 0, 14'd0, 32'h0, 0, 0, 0));
        vq.push_back(mk(1, 8'h34, 0, 14'd0, 32'h0, 0, 0, 0));
        vq.push_back(mk(1, 8'h12, 1, 14'd0, 32'h12345678, 0, 0, 0));
        vq.push_back(mk(1, 8'hEF, 0, 14'd0, 32'h12345678, 0, 0, 0));
        vq.push_back(mk(1, 8'hBE, 0, 14'd0, 32'h12345678, 0, 0, 0));
        vq.push_back(mk(1, 8'hAD, 0, 14'd0, 32'h12345678, 0, 0, 0));
        vq.push_back(mk(1, 8'hDE, 1, 14'd1, 32'hDEADBEEF, 0, 0, 0));
        vq.push_back(mk(0, 8'h00, 0, 14'd1, 32'hDEADBEEF, 0, 1, 0));
        // bad command in idle, then dmem frame N=1 with bytes every cycle
        vq.push_back(mk(1, 8'h7F, 0, 14'd1, 32'hDEADBEEF, 0, 1, 1));
        vq.push_back(mk(0, 8'h00, 0, 14'd1, 32'hDEADBEEF, 0, 1, 1));
        vq.push_back(mk(1, 8'h01, 0, 14'd1, 32'hDEADBEEF, 1, 0, 0));
        vq.push_back(mk(1, 8'h01, 0, 14'd1, 32'hDEADBEEF, 1, 0, 0));
        vq.push_back(mk(1, 8'h00, 0, 14'd1, 32'hDEADBEEF, 1, 0, 0));
        vq.push_back(mk(1, 8'h11, 0, 14'd1, 32'hDEADBEEF, 1, 0, 0));
        vq.push_back(mk(1, 8'h22, 0, 14'd1, 32'hDEADBEEF, 1, 0, 0));
        vq.push_back(mk(1, 8'h33, 0, 14'd1, 32'hDEADBEEF, 1, 0, 0));
        vq.push_back(mk(1, 8'h44, 1, 14'd0, 32'h44332211, 1, 0, 0));
        vq.push_back(mk(0, 8'h00, 0, 14'd0, 32'h44332211, 1, 1, 0));
        // N=0 frame ends right after LEN_H
        vq.push_back(mk(1, 8'h00, 0, 14'd0, 32'h44332211, 0, 0, 0));
        vq.push_back(mk(1, 8'h00, 0, 14'd0, 32'h44332211, 0, 0, 0));
        vq.push_back(mk(1, 8'h00, 0, 14'd0, 32'h44332211, 0, 1, 0));
        // N=0x4001 exceeds 2^14 words
        vq.push_back(mk(1, 8'h00, 0, 14'd0, 32'h44332211, 0, 0, 0));
        vq.push_back(mk(1, 8'h01, 0, 14'd0, 32'h44332211, 0, 0, 0));
        vq.push_back(mk(1, 8'h40, 0, 14'd0, 32'h44332211, 0, 1, 1));

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].v, vq[i].d);
            check($sformatf("vec%0d", i), obs(),
                  ex(vq[i].wen, vq[i].adr, vq[i].dat, vq[i].sel, vq[i].done, vq[i].err));
        end

        // N=0x4000 is the largest legal length; a byte on the timeout cycle is dropped
        step(1, 8'h00); step(1, 8'h00); step(1, 8'h40);
        check("len_max_ok", {62'd0, done, err}, 64'd0);
        for (int k = 0; k < 15; k++) tick();
        check("len_max_hold", {63'd0, done}, 64'd0);
        step(1, 8'h00);
        check("tmo_wins", {62'd0, done, err}, 64'd3);
        tick();
        check("tmo_byte_dropped", {62'd0, done, err}, 64'd3);

        // N=2 frame abandoned after 5 data bytes
        step(1, 8'h00); step(1, 8'h02); step(1, 8'h00);
        step(1, 8'h01); step(1, 8'h02); step(1, 8'h03); step(1, 8'h04);
        check("tmo_word0", obs(), ex(1, 14'd0, 32'h04030201, 0, 0, 0));
        step(1, 8'h05);
        saw_wen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (wen) saw_wen = 1'b1;
        end
        check("tmo_pending", {62'd0, done, saw_wen}, 64'd0);
        tick();
        check("tmo_fire", obs(), ex(0, 14'd0, 32'h04030201, 0, 1, 1));
        step(1, 8'h00); step(1, 8'h01); step(1, 8'h00);
        step(1, 8'hA0); step(1, 8'hA1); step(1, 8'hA2); step(1, 8'hA3);
        check("after_tmo_word", obs(), ex(1, 14'd0, 32'hA3A2A1A0, 0, 0, 0));
        tick();
        check("after_tmo_done", {62'd0, done, wen}, 64'd2);
`endif

        // reset in the middle of a word
        step(1, 8'h01); step(1, 8'h01); step(1, 8'h00);
        step(1, 8'h10); step(1, 8'h20);
        rst = 1'b1;
        step(1, 8'h30);
        check("mid_reset", obs(), ex(0, 14'd0, 32'h0, 0, 1, 0));
        rst = 1'b0;
        step(1, 8'h00); step(1, 8'h01); step(1, 8'h00);
        step(1, 8'h5A); step(1, 8'h6B); step(1, 8'h7C);
        check("post_reset_nowr", {63'd0, wen}, 64'd0);
        step(1, 8'h8D);
`ifndef UPG_CHECKSUM_EN
        check("post_reset_word", obs(), ex(1, 14'd0, 32'h8D7C6B5A, 0, 0, 0));
        tick();
        check("post_reset_done", {62'd0, done, err}, 64'd2);
`else
        check("post_reset_word", obs(), ex(1, 14'd0, 32'h8D7C6B5A, 0, 0, 0));
        step(1, 8'h01 ^ 8'h5A ^ 8'h6B ^ 8'h7C ^ 8'h8D);
        check("post_reset_chk", {62'd0, done, err}, 64'd2);

        // wrong checksum: write still happens, err set at CHK
        step(1, 8'h01); step(1, 8'h01); step(1, 8'h00);
        step(1, 8'h10); step(1, 8'h20); step(1, 8'h30); step(1, 8'h40);
        check("chk_word", obs(), ex(1, 14'd0, 32'h40302010, 1, 0, 0));
        tick();
        check("chk_wait", {62'd0, done, err}, 64'd0);
        step(1, 8'h00);
        check("chk_bad", {62'd0, done, err}, 64'd3);
        step(1, 8'h01);
        check("chk_err_clear", {62'd0, done, err}, 64'd0);
        step(1, 8'h01); step(1, 8'h00);
        step(1, 8'h10); step(1, 8'h20); step(1, 8'h30); step(1, 8'h40);
        check("chk_word2", obs(), ex(1, 14'd0, 32'h40302010, 1, 0, 0));
        step(1, 8'h41);
        check("chk_good", {62'd0, done, err}, 64'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
